// File: rtl/rs232_echo_checker.sv
// rs232_echo_checker
//   Host-side initiator for the +1 serial echo path. Sends NUM_BYTES payload
//   bytes as 8N1 frames on tx, receives each echo on rx and checks that
//   echo == payload + 1 (mod 256). Counts bytes sent and errors (mismatch,
//   echo timeout, framing, unexpected byte while busy).
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a run when idle or done
//   rx         in   serial echo input (asynchronous, idles high)
//   tx         out  serial output (idles high)
//   busy       out  run in progress
//   done       out  run finished, held until the next accepted start
//   pass       out  done and no errors
//   byte_count out  bytes sent in the current or last run
//   err_count  out  saturating error count
//
// Build option
//   ECHO_CHECKER_LFSR_EN : payload advances as an 8-bit Fibonacci LFSR
//                          (x^8+x^6+x^5+x^4+1) instead of incrementing.
module rs232_echo_checker #(
  parameter int unsigned PERIOD    = 10,
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned TIMEOUT   = 200,
  parameter logic [7:0]  SEED      = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] byte_count,
  output logic [15:0] err_count
);

  localparam logic [15:0] BIT_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] BIT_HALF = 16'(PERIOD / 2 - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] N_BYTES  = 16'(NUM_BYTES);

`ifdef ECHO_CHECKER_LFSR_EN
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
`else
  localparam logic [7:0] SEED_EFF = SEED;
`endif

  function automatic logic [7:0] advance(input logic [7:0] p);
`ifdef ECHO_CHECKER_LFSR_EN
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
`else
    return p + 8'd1;
`endif
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_ECHO, S_NEXT, S_DONE} state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  // ---------------- receiver ----------------
  logic        sync1_q, sync2_q, rxprev_q;
  rx_state_e   rs_q, rs_d;
  logic [15:0] rcnt_q, rcnt_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rshift_q, rshift_d;
  logic        rx_valid, rx_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxprev_q <= 1'b1;
      rs_q     <= R_IDLE;
      rcnt_q   <= '0;
      rbit_q   <= '0;
      rshift_q <= '0;
    end else begin
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      rxprev_q <= sync2_q;
      rs_q     <= rs_d;
      rcnt_q   <= rcnt_d;
      rbit_q   <= rbit_d;
      rshift_q <= rshift_d;
    end
  end

  always_comb begin
    rs_d     = rs_q;
    rcnt_d   = rcnt_q + 16'd1;
    rbit_d   = rbit_q;
    rshift_d = rshift_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        rcnt_d = '0;
        if (rxprev_q && !sync2_q) rs_d = R_START;
      end
      R_START: begin
        if (rcnt_q == BIT_HALF) begin
          rcnt_d = '0;
          rbit_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          rs_d   = sync2_q ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d   = '0;
          rshift_d = {sync2_q, rshift_q[7:1]};
          rbit_d   = rbit_q + 3'd1;
          if (rbit_q == 3'd7) rs_d = R_STOP;
        end
      end
      R_STOP: begin
        if (rcnt_q == BIT_LAST) begin
          rcnt_d   = '0;
          rs_d     = R_IDLE;
          rx_valid = sync2_q;
          rx_ferr  = !sync2_q;
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  // ---------------- initiator FSM ----------------
  state_e      state_q, state_d;
  logic [7:0]  payload_q, payload_d;
  logic [8:0]  shreg_q, shreg_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] to_q, to_d;
  logic [15:0] bytes_q, bytes_d;
  logic [15:0] err_q, err_d;
  logic        tx_q, tx_d;
  logic        fsm_err, unexp, clear_err;
  logic [16:0] err_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      payload_q <= SEED_EFF;
      shreg_q   <= '1;
      bit_q     <= '0;
      baud_q    <= '0;
      to_q      <= '0;
      bytes_q   <= '0;
      err_q     <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      baud_q    <= baud_d;
      to_q      <= to_d;
      bytes_q   <= bytes_d;
      err_q     <= err_d;
      tx_q      <= tx_d;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    baud_d    = baud_q;
    to_d      = to_q;
    bytes_d   = bytes_q;
    tx_d      = tx_q;
    fsm_err   = 1'b0;
    clear_err = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          bytes_d   = '0;
          clear_err = 1'b1;
          payload_d = SEED_EFF;
        end
      end
      S_LOAD: begin
        // Start bit is driven from the register so tx falls on the next cycle;
        // shreg holds {stop, data} and shifts out LSB first.
        shreg_d = {1'b1, payload_q};
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        baud_d = baud_q + 16'd1;
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bytes_d = bytes_q + 16'd1;
            to_d    = '0;
            state_d = S_WAIT_ECHO;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = {1'b1, shreg_q[8:1]};
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      S_WAIT_ECHO: begin
        to_d = to_q + 16'd1;
        if (rx_valid) begin
          fsm_err = (rshift_q != payload_q + 8'd1);
          state_d = S_NEXT;
        end else if (to_q == TO_LAST) begin
          fsm_err = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        payload_d = advance(payload_q);
        state_d   = (bytes_q == N_BYTES) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and receiver errors can land on the same cycle; sum then saturate.
  assign unexp   = rx_valid && busy && (state_q != S_WAIT_ECHO);
  assign err_sum = {1'b0, err_q} + 17'(fsm_err) + 17'(rx_ferr) + 17'(unexp);
  assign err_d   = clear_err ? '0 : (err_sum[16] ? '1 : err_sum[15:0]);

  assign tx         = tx_q;
  assign done       = (state_q == S_DONE);
  assign pass       = done && (err_q == '0);
  assign byte_count = bytes_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_rs232_echo_checker.sv
// Self-checking bench for rs232_echo_checker: a scripted loopback responder
// echoes each transmitted byte according to a per-byte action; expected tx
// bytes and end-of-run results are queued at launch and checked by monitors.
module tb_rs232_echo_checker;

  localparam int P = 8;
  localparam int N = 4;
  localparam int T = 200;
  localparam logic [7:0] SEED = 8'hFE;
  localparam int BUDGET = N * (10 * P + T + 2) + 100;

`ifdef ECHO_CHECKER_LFSR_EN
  localparam logic [7:0] SEED_M = (SEED == 8'h00) ? 8'h01 : SEED;
`else
  localparam logic [7:0] SEED_M = SEED;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic rx = 1'b1;
  logic tx, busy, done, pass;
  logic [15:0] byte_count, err_count;

  always #5 clk = ~clk;

  rs232_echo_checker #(
    .PERIOD(P), .NUM_BYTES(N), .TIMEOUT(T), .SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(rx), .tx(tx),
    .busy(busy), .done(done), .pass(pass),
    .byte_count(byte_count), .err_count(err_count)
  );

  typedef enum int {A_OK, A_BAD, A_NONE, A_FRAME, A_GLITCH} act_e;
  typedef struct { int err; int bytes; } res_t;
  typedef struct { logic [7:0] b; act_e a; } resp_t;

  logic [7:0] exp_tx[$];
  act_e       act_q[$];
  res_t       exp_res[$];
  resp_t      resp_q[$];
  act_e       cur_acts[N];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] b);
`ifdef ECHO_CHECKER_LFSR_EN
    return {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
`else
    return 8'(b + 8'd1);
`endif
  endfunction

  function automatic int err_of(input act_e a);
    case (a)
      A_BAD, A_NONE: return 1;
      A_FRAME:       return 2;  // framing error, then echo timeout
      default:       return 0;
    endcase
  endfunction

  task automatic wait_n(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst_n) begin ok = 1'b0; return; end
    end
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop_bit, output bit ok);
    rx = 1'b0;
    wait_n(P, ok);
    if (!ok) begin rx = 1'b1; return; end
    for (int k = 0; k < 8; k++) begin
      rx = v[k];
      wait_n(P, ok);
      if (!ok) begin rx = 1'b1; return; end
    end
    rx = stop_bit;
    wait_n(P, ok);
    rx = 1'b1;
  endtask

  task automatic decode_tx(output logic [7:0] b, output bit ok);
    b = '0;
    wait_n(P / 2, ok);
    if (!ok) return;
    chk("tx_start_bit", 32'(tx), 32'd0);
    for (int k = 0; k < 8; k++) begin
      wait_n(P, ok);
      if (!ok) return;
      b[k] = tx;
    end
    wait_n(P, ok);
    if (!ok) return;
    chk("tx_stop_bit", 32'(tx), 32'd1);
  endtask

  // tx monitor: decodes frames, checks against queued payloads, hands to responder
  initial begin : tx_monitor
    logic       tx_prev;
    logic [7:0] b;
    logic [7:0] e;
    bit         ok;
    act_e       a;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_prev = 1'b1;
      end else if (tx_prev && !tx) begin
        decode_tx(b, ok);
        if (ok) begin
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_byte: got %02h, expected no frame", b);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", 32'(b), 32'(e));
          end
          a = (act_q.size() != 0) ? act_q.pop_front() : A_NONE;
          resp_q.push_back('{b, a});
        end
        tx_prev = tx;
      end else begin
        tx_prev = tx;
      end
    end
  end

  // loopback responder: replies 3 bit-times after the frame ends
  initial begin : responder
    resp_t      r;
    bit         ok;
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (rst_n && resp_q.size() != 0) begin
        r = resp_q.pop_front();
        wait_n(P / 2 + 3 * P, ok);
        if (ok) begin
          case (r.a)
            A_OK:    send_frame(8'(r.b + 8'd1), 1'b1, ok);
            A_BAD: begin
              v = 8'($urandom_range(0, 255));
              if (v == 8'(r.b + 8'd1)) v = v ^ 8'h01;
              send_frame(v, 1'b1, ok);
            end
            A_FRAME: send_frame(8'(r.b + 8'd1), 1'b0, ok);
            A_GLITCH: begin
              rx = 1'b0;
              wait_n(2, ok);
              rx = 1'b1;
              if (ok) wait_n(P, ok);
              if (ok) send_frame(8'(r.b + 8'd1), 1'b1, ok);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // done monitor: checks end-of-run results on each rising done
  initial begin : done_monitor
    logic done_prev;
    res_t r;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done && !done_prev) begin
        if (exp_res.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_event: got done=1, expected no run outstanding");
        end else begin
          r = exp_res.pop_front();
          chk("err_count", 32'(err_count), 32'(r.err));
          chk("byte_count", 32'(byte_count), 32'(r.bytes));
          chk("pass", 32'(pass), 32'(r.err == 0));
          chk("busy_at_done", 32'(busy), 32'd0);
          chk("all_bytes_sent", 32'(exp_tx.size()), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  task automatic launch();
    logic [7:0] b;
    int e;
    b = SEED_M;
    e = 0;
    for (int i = 0; i < N; i++) begin
      exp_tx.push_back(b);
      act_q.push_back(cur_acts[i]);
      e += err_of(cur_acts[i]);
      b = model_next(b);
    end
    exp_res.push_back('{e, N});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input bit poke, output int cyc);
    cyc = 1;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 30);  // start while busy must be ignored
    end
    start = 1'b0;
    chk("done_within_budget", 32'(done), 32'd1);
  endtask

  task automatic run(input bit poke, output int cyc);
    launch();
    wait_done(poke, cyc);
    repeat (4 * P) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    int cyc;
    int lat;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cur_acts = '{A_OK, A_OK, A_OK, A_OK};
    run(1'b0, cyc);
    cur_acts = '{A_OK, A_BAD, A_OK, A_OK};
    run(1'b0, cyc);

    cur_acts = '{A_NONE, A_NONE, A_NONE, A_NONE};
    run(1'b0, cyc);
    lat = N * (10 * P + T + 2) + 1;
    checks++;
    if (cyc < lat - 3 || cyc > lat + 3) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles, expected %0d +/-3", cyc, lat);
    end

    cur_acts = '{A_OK, A_FRAME, A_OK, A_OK};
    run(1'b0, cyc);
    cur_acts = '{A_GLITCH, A_OK, A_GLITCH, A_OK};
    run(1'b0, cyc);

    // reset in the middle of a data bit of the third byte (payload 8'h00)
    cur_acts = '{A_OK, A_OK, A_OK, A_OK};
    launch();
    cyc = 0;
    while (byte_count != 16'd2 && cyc < BUDGET) begin @(negedge clk); cyc++; end
    chk("reached_byte3", 32'(byte_count), 32'd2);
    cyc = 0;
    while (tx !== 1'b0 && cyc < BUDGET) begin @(negedge clk); cyc++; end
    repeat (2 * P + P / 2) @(negedge clk);
    chk("tx_mid_byte3", 32'(tx), 32'd0);
    #2;
    rst_n = 1'b0;
    exp_tx.delete(); act_q.delete(); resp_q.delete(); exp_res.delete();
    #1;
    check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run(1'b0, cyc);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) cur_acts[i] = act_e'($urandom_range(0, 4));
      run(1'b1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_echo_checker.md
Name: rs232_echo_checker

Overview:
Host-side initiator for the +1 serial echo path. It transmits a sequence of bytes over 8N1 RS-232, receives each echoed byte, and checks that the echo equals the sent byte plus 1 (mod 256). Error and byte counters plus pass/done flags are reported for on-board self-test and for bench stimulus.

Parameters:
PERIOD, 10, clock cycles per serial bit. Must be >= 4.
NUM_BYTES, 16, number of bytes per run, 1..65535.
TIMEOUT, 200, cycles to wait for an echo after the stop bit is sent.
SEED, 8'h00, first payload byte.

Ports:
clk  input  1  system clock
rst_n  input  1  reset: asynchronous assert, active-low
start  input  1  one-cycle pulse; begins a run when idle
rx  input  1  serial input carrying the echo; asynchronous, idles high
tx  output  1  serial output, idles high
busy  output  1  high while a run is in progress
done  output  1  high from end of run until the next accepted start
pass  output  1  done & (err_count == 0)
byte_count  output  16  bytes sent in the current or last run
err_count  output  16  mismatch + timeout + framing + unexpected errors; saturates at 16'hFFFF

Behaviour:
- Reset values: tx=1, busy=0, done=0, pass=0, byte_count=0, err_count=0; FSM=IDLE; receiver idle; payload=SEED.
- Reset asserted mid-frame: tx=1 immediately (asynchronous). No partial frame resumes.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly PERIOD cycles, so a frame is 10*PERIOD cycles.
- FSM states: IDLE, LOAD, SEND, WAIT_ECHO, NEXT, DONE.
- IDLE/DONE, start=1: clear byte_count and err_count, done=0, busy=1, payload=SEED, go to LOAD. Start while busy is ignored.
- LOAD (1 cycle): latch payload into the shift register, go to SEND.
- SEND: serialise the frame. tx goes low on the cycle after LOAD. At the end of the stop bit: byte_count += 1, clear the timeout counter, go to WAIT_ECHO.
- WAIT_ECHO:
  - Receiver delivers a byte: if byte != payload+1, err +1. Go to NEXT.
  - Timeout counter reaches TIMEOUT: err +1, go to NEXT.
  - Delivery and timeout on the same cycle: delivery wins (compare only, no timeout error).
- NEXT: advance payload (+1, wrapping 8'hFF -> 8'h00). If byte_count == NUM_BYTES go to DONE (busy=0, done=1); otherwise go to LOAD. No extra idle bit time is inserted.
- Receiver (always active, independent of the FSM):
  - 2-flop synchroniser on rx.
  - Falling edge starts a frame; sample at PERIOD/2. If the start bit reads 1, abort as a glitch (no error).
  - Sample 8 data bits, then the stop bit, each PERIOD cycles apart.
  - Stop bit = 0: framing error, err +1, byte discarded.
  - Otherwise pulse an internal rx_valid for one cycle.
- rx_valid outside WAIT_ECHO (unexpected byte, including while in IDLE/DONE after a run): err +1 only when busy; ignored when not busy.
- Errors from the FSM and the receiver on the same cycle add 2 (saturating).
- pass is combinational from done and err_count.

Optional Feature:
ECHO_CHECKER_LFSR_EN:
- Defined: payload advances as an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0. If SEED is 0, 8'h01 is used as the seed. The echo check is still payload+1.
- Undefined: incrementing payload as above.

Test Plan:
- Loopback model returning byte+1 after 3*PERIOD idle; NUM_BYTES=4, SEED=8'hFE: tx bytes FE,FF,00,01; echoes FF,00,01,02. Expect done=1, pass=1, err_count=0, byte_count=4.
- Same model, but the 2nd echo is 8'h55: expect err_count=1, pass=0, byte_count=4.
- rx held high, NUM_BYTES=3, TIMEOUT=50: expect err_count=3, and done asserted at 3*(10*PERIOD+50)+overhead cycles.
- Echo with stop bit driven 0: framing error plus a timeout for that byte, err_count=2 for that byte.
- rx low pulse shorter than PERIOD/2 during WAIT_ECHO: no error; the subsequent valid echo passes.
- rst_n asserted mid-data-bit of byte 2: tx=1 in the same cycle, all outputs at reset values; a new start runs cleanly with pass=1.
